spu_op_sequencer: RTL and testbench
===================================

// Module: spu_op_sequencer
// PURPOSE
//  Command sequencer for the SPU shape units (mul, div, pot, cap, ab2, dxy, cad, cd2, cd3, cam, alt).
//  Accepts one command on a valid/ready interface and drives the shared operand bus and unit select.
//  Holds operands stable for SETTLE cycles, then captures the selected unit result into a response register.
//  Sits between the SPU instruction decoder and the combinational shape units plus their result mux.
// PARAMETERS
//  N       32  datapath width of all operands and results
//  SETTLE  2   extra cycles operands are held before capture (0..15)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst        in   1   synchronous reset, active-high
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   sequencer can accept a command
//  cmd_op     in   4   opcode: 0 mul, 1 div, 2 pot, 3 cap, 4 ab2, 5 dxy, 6 cad, 7 cd2, 8 cd3, 9 cam, 10 alt; 11-15 illegal
//  cmd_a/cmd_b/cmd_m/cmd_p/cmd_d  in  N  operands a, b, M, P, D
//  op_sel     out  4   unit select to the external result mux; equals the latched opcode
//  op_a/op_b/op_m/op_p/op_d       out N  registered operand bus to all units
//  unit_res   in   N   selected unit result; alt's 2-bit result arrives zero-extended
//  rsp_valid  out  1   response available
//  rsp_ready  in   1   consumer takes the response
//  rsp_data   out  N   captured result
//  rsp_op     out  4   opcode the response belongs to
//  rsp_err    out  1   illegal opcode (or divide-by-zero, see CONFIGURATION)
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  FSM states: IDLE, WAIT, DONE. Only one command is in flight; there is no overlap.
//  Reset: state IDLE, counter 0, and all op_*/rsp_* outputs 0. busy=0.
//   cmd_ready is 0 while rst=1 and 1 on the first cycle after rst deasserts.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch the opcode into op_sel/rsp_op and the operands into op_*.
//   Legal opcode: cnt<=SETTLE, go to WAIT.
//   Illegal opcode: rsp_err<=1, rsp_data<=0, go to DONE. op_* are still updated.
//  WAIT: cmd_ready=0, op_* held. If cnt==0: rsp_data<=unit_res, rsp_err<=0, go to DONE; else cnt--.
//   WAIT therefore lasts SETTLE+1 cycles.
//  DONE: rsp_valid=1, and rsp_data/rsp_op/rsp_err are held stable. On rsp_ready, go to IDLE next cycle.
//   cmd_ready=0 throughout DONE.
//  Latency: accept in cycle t gives rsp_valid in cycle t+SETTLE+2. Illegal opcode gives rsp_valid at t+1.
//  Throughput: with rsp_ready tied to 1, one command every SETTLE+3 cycles.
//  rsp_* retain their values after the handshake until the next capture. op_* retain until the next accept.
//  rsp_ready while rsp_valid=0 is ignored. cmd_valid outside IDLE is ignored; it is never dropped silently,
//   because cmd_ready=0 there.
//  Reset mid-WAIT or mid-DONE: the response is discarded, and the reset values above apply on the next cycle.
//  No arithmetic in this block: unit_res is captured bit-exact, with no width conversion.
// CONFIGURATION
//  SPU_DIVZERO_CHK_EN defined:
//   In IDLE, an accept of op 1 (div) with cmd_b==0 sets rsp_data<=all ones and rsp_err<=1, skips WAIT, and
//   goes to DONE (rsp_valid at t+1). op_* are still updated.
//  Not defined: div with b==0 takes the normal WAIT path. rsp_data = unit_res and rsp_err = 0.
// TESTING (SETTLE=2, N=32, bench instantiates the real units behind a mux on op_sel)
//  1. Reset: hold rst 3 cycles -> all outputs 0 and cmd_ready=0; cmd_ready=1 on the cycle after release.
//  2. mul a=2, b=4 accepted at cycle t -> rsp_valid at t+4, rsp_data=8, rsp_op=0, rsp_err=0.
//  3. op 12 accepted at t -> rsp_valid at t+1, rsp_err=1, rsp_data=0, busy=1 until the handshake.
//  4. Backpressure: div a=65, b=5 -> rsp_data=13. With rsp_ready=0 for 6 cycles, rsp_* stay constant and
//     cmd_ready stays 0. A second cmd_valid is held and is accepted 1 cycle after the handshake.
//  5. div a=65, b=0 -> with SPU_DIVZERO_CHK_EN: rsp_err=1, rsp_data=32'hFFFFFFFF at t+1;
//     without it: rsp_valid at t+4, rsp_err=0.
//  6. Reset asserted in the second WAIT cycle of an ab2 command -> no rsp_valid; the next command (cd3,
//     D=2, a=9, b=34) completes normally with the latency of scenario 2.

Source files
------------

// File: rtl/spu_op_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : spu_op_sequencer
// Description : Single-command sequencer for the SPU shape units. Drives the
//               shared operand bus and unit select, waits SETTLE cycles, then
//               captures the selected unit result. Optional macro
//               SPU_DIVZERO_CHK_EN short-circuits div-by-zero to an error.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module spu_op_sequencer #(
    parameter int N      = 32,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [N-1:0] cmd_m,
    input  logic [N-1:0] cmd_p,
    input  logic [N-1:0] cmd_d,
    output logic [3:0]   op_sel,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [N-1:0] op_m,
    output logic [N-1:0] op_p,
    output logic [N-1:0] op_d,
    input  logic [N-1:0] unit_res,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [3:0]   rsp_op,
    output logic         rsp_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_settle   = 4'(SETTLE);
    localparam logic [3:0] c_op_div   = 4'd1;
    localparam logic [3:0] c_op_last  = 4'd10;

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [3:0]   r_op_sel;
    logic [N-1:0] r_op_a;
    logic [N-1:0] r_op_b;
    logic [N-1:0] r_op_m;
    logic [N-1:0] r_op_p;
    logic [N-1:0] r_op_d;
    logic [N-1:0] r_rsp_data;
    logic [3:0]   r_rsp_op;
    logic         r_rsp_err;

    logic         w_accept;
    logic         w_legal;
    logic         w_divzero;

    // Ready is gated by rst so no command can slip in while reset is asserted.
    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_legal   = (cmd_op <= c_op_last);

`ifdef SPU_DIVZERO_CHK_EN
    assign w_divzero = (cmd_op == c_op_div) && (cmd_b == '0);
`else
    assign w_divzero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op_sel   <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_m     <= '0;
            r_op_p     <= '0;
            r_op_d     <= '0;
            r_rsp_data <= '0;
            r_rsp_op   <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_sel <= cmd_op;
                        r_rsp_op <= cmd_op;
                        r_op_a   <= cmd_a;
                        r_op_b   <= cmd_b;
                        r_op_m   <= cmd_m;
                        r_op_p   <= cmd_p;
                        r_op_d   <= cmd_d;
                        if (!w_legal) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_state    <= ST_DONE;
                        end else if (w_divzero) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_cnt   <= c_settle;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Capture on the cycle the counter has already reached zero,
                    // giving SETTLE+1 cycles of stable operands at the units.
                    if (r_cnt == '0) begin
                        r_rsp_data <= unit_res;
                        r_rsp_err  <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign op_sel    = r_op_sel;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign op_m      = r_op_m;
    assign op_p      = r_op_p;
    assign op_d      = r_op_d;
    assign rsp_data  = r_rsp_data;
    assign rsp_op    = r_rsp_op;
    assign rsp_err   = r_rsp_err;
    assign rsp_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spu_op_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_spu_op_sequencer
// Description : Directed bench for spu_op_sequencer (N=32, SETTLE=2) with a
//               behavioural stand-in for the shape-unit result mux.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_spu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b, cmd_m, cmd_p, cmd_d;
    logic [3:0]  op_sel;
    logic [31:0] op_a, op_b, op_m, op_p, op_d;
    logic [31:0] unit_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    spu_op_sequencer #(.N(32), .SETTLE(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_m(cmd_m), .cmd_p(cmd_p), .cmd_d(cmd_d),
        .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .op_m(op_m), .op_p(op_p), .op_d(op_d),
        .unit_res(unit_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in units: mul and div are exact; cd3 is modelled as a+b+D; the
    // rest return a tag so a wrong select is visible.
    function automatic logic [31:0] unit_model(input logic [3:0] op,
                                               input logic [31:0] a, b, d);
        case (op)
            4'd0:    unit_model = a * b;
            4'd1:    unit_model = (b == 0) ? 32'h0000_DEAD : a / b;
            4'd8:    unit_model = a + b + d;
            default: unit_model = a ^ b ^ {28'h0, op};
        endcase
    endfunction

    always_comb unit_res = unit_model(op_sel, op_a, op_b, op_d);

    // Drive one command for one cycle; returns just after the following negedge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, b, d);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_m = a + 1; cmd_p = b + 1; cmd_d = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    // Latency counted in cycles from the accept cycle.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_m = '0; cmd_p = '0; cmd_d = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
        checks++;
        if ({rsp_valid, busy, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {rsp_valid, busy, rsp_err}); end
        checks++;
        if ({rsp_data, rsp_op, op_sel} !== 40'h0) begin errors++; $display("FAIL reset_rsp got %h want 0", {rsp_data, rsp_op, op_sel}); end
        checks++;
        if ({op_a, op_b, op_m, op_p, op_d} !== 160'h0) begin errors++; $display("FAIL reset_opbus got %h want 0", {op_a, op_b, op_m, op_p, op_d}); end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_mul();
        int lat;
        send(4'd0, 32'd2, 32'd4, 32'd0);
        checks++;
        if ({busy, cmd_ready, rsp_valid} !== 3'b100) begin errors++; $display("FAIL mul_wait_flags got %b want 100", {busy, cmd_ready, rsp_valid}); end
        wait_rsp(lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL mul_latency got %0d want 4", lat); end
        checks++;
        if (rsp_data !== 32'd8 || rsp_op !== 4'd0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL mul_rsp got data=%0d op=%0d err=%b want 8 0 0", rsp_data, rsp_op, rsp_err);
        end
        checks++;
        if (op_a !== 32'd2 || op_b !== 32'd4 || op_m !== 32'd3 || op_p !== 32'd5) begin
            errors++; $display("FAIL mul_opbus got a=%0d b=%0d m=%0d p=%0d want 2 4 3 5", op_a, op_b, op_m, op_p);
        end
        release_rsp();
        checks++;
        if ({busy, cmd_ready, rsp_valid} !== 3'b010 || rsp_data !== 32'd8) begin
            errors++; $display("FAIL mul_after_hs got flags=%b data=%0d want 010 8", {busy, cmd_ready, rsp_valid}, rsp_data);
        end
    endtask

    task automatic test_illegal();
        int lat;
        send(4'd12, 32'h55, 32'h66, 32'h0);
        wait_rsp(lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_op !== 4'd12) begin
            errors++; $display("FAIL illegal_rsp got err=%b data=%h op=%0d want 1 0 12", rsp_err, rsp_data, rsp_op);
        end
        checks++;
        if (op_a !== 32'h55 || op_sel !== 4'd12) begin errors++; $display("FAIL illegal_opbus got a=%h sel=%0d want 55 12", op_a, op_sel); end
        repeat (2) begin @(negedge clk); #1; end
        checks++;
        if ({busy, rsp_valid, rsp_err, cmd_ready} !== 4'b1110) begin
            errors++; $display("FAIL illegal_hold got %b want 1110", {busy, rsp_valid, rsp_err, cmd_ready});
        end
        release_rsp();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL illegal_release busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int lat;
        send(4'd1, 32'd65, 32'd5, 32'd0);
        wait_rsp(lat);
        checks++;
        if (lat !== 4 || rsp_data !== 32'd13) begin errors++; $display("FAIL div_rsp got lat=%0d data=%0d want 4 13", lat, rsp_data); end
        cmd_op = 4'd0; cmd_a = 32'd3; cmd_b = 32'd7; cmd_m = 32'd0; cmd_p = 32'd0; cmd_d = 32'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd13 || rsp_op !== 4'd1 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cycle %0d got v=%b data=%0d op=%0d err=%b rdy=%b want 1 13 1 0 0",
                                   i, rsp_valid, rsp_data, rsp_op, rsp_err, cmd_ready);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_data !== 32'd13) begin
            errors++; $display("FAIL bp_second_accept got rdy=%b data=%0d want 1 13", cmd_ready, rsp_data);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || op_a !== 32'd3 || rsp_op !== 4'd0) begin
            errors++; $display("FAIL bp_second_latched got busy=%b a=%0d op=%0d want 1 3 0", busy, op_a, rsp_op);
        end
        wait_rsp(lat);
        checks++;
        if (lat !== 4 || rsp_data !== 32'd21) begin errors++; $display("FAIL bp_second_rsp got lat=%0d data=%0d want 4 21", lat, rsp_data); end
        release_rsp();
    endtask

    task automatic test_divzero();
        int lat;
        send(4'd1, 32'd65, 32'd0, 32'd0);
        wait_rsp(lat);
`ifdef SPU_DIVZERO_CHK_EN
        checks++;
        if (lat !== 1 || rsp_err !== 1'b1 || rsp_data !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divzero got lat=%0d err=%b data=%h want 1 1 ffffffff", lat, rsp_err, rsp_data);
        end
`else
        checks++;
        if (lat !== 4 || rsp_err !== 1'b0 || rsp_data !== 32'h0000_DEAD) begin
            errors++; $display("FAIL divzero got lat=%0d err=%b data=%h want 4 0 0000dead", lat, rsp_err, rsp_data);
        end
`endif
        checks++;
        if (op_a !== 32'd65 || op_b !== 32'd0 || rsp_op !== 4'd1) begin
            errors++; $display("FAIL divzero_opbus got a=%0d b=%0d op=%0d want 65 0 1", op_a, op_b, rsp_op);
        end
        release_rsp();
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        send(4'd4, 32'h11, 32'h22, 32'h0);
        @(negedge clk); #1;
        checks++;
        if ({busy, rsp_valid} !== 2'b10) begin errors++; $display("FAIL ab2_wait got %b want 10", {busy, rsp_valid}); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b000 || op_a !== 32'h0 || rsp_data !== 32'h0 || rsp_op !== 4'd0) begin
            errors++; $display("FAIL midwait_reset got flags=%b a=%h data=%h op=%0d want 000 0 0 0",
                               {rsp_valid, busy, cmd_ready}, op_a, rsp_data, rsp_op);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midwait_release rdy got %b want 1", cmd_ready); end
        send(4'd8, 32'd9, 32'd34, 32'd2);
        wait_rsp(lat);
        checks++;
        if (lat !== 4 || rsp_data !== 32'd45 || rsp_op !== 4'd8 || rsp_err !== 1'b0 || op_d !== 32'd2) begin
            errors++; $display("FAIL cd3_rsp got lat=%0d data=%0d op=%0d err=%b d=%0d want 4 45 8 0 2",
                               lat, rsp_data, rsp_op, rsp_err, op_d);
        end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        rsp_ready = 1'b1;
        cmd_op = 4'd0; cmd_a = 32'd6; cmd_b = 32'd7; cmd_m = 32'd0; cmd_p = 32'd0; cmd_d = 32'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cmd_ready === 1'b1) acc.push_back(i);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (acc.size() !== 4) begin errors++; $display("FAIL b2b_accepts got %0d want 4", acc.size()); end
        for (int k = 1; k < acc.size(); k++) begin
            checks++;
            if (acc[k] - acc[k-1] !== 5) begin errors++; $display("FAIL b2b_gap %0d got %0d want 5", k, acc[k] - acc[k-1]); end
        end
        repeat (6) @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_data !== 32'd42) begin errors++; $display("FAIL b2b_end got busy=%b data=%0d want 0 42", busy, rsp_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_illegal();
        test_backpressure();
        test_divzero();
        test_reset_mid_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
